delay_and_scale: RTL and testbench

DELAY_AND_SCALE -- requirements
Module: delay_and_scale

---
 rtl/delay_and_scale.sv | 88 ++++++++
 tb/tb_delay_and_scale.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_and_scale.sv
// Delay-line gain stage: 256-deep sample history, selectable tap, unsigned Q1.4 gain, 2-cycle latency.
// Overflow: define DELAY_AND_SCALE_SATURATE_EN to clamp the result; otherwise the low 16 bits wrap.
module delay_and_scale (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        ready_in,
  input  logic [7:0]  delay_in,
  input  logic [4:0]  scale_in,
  input  logic [15:0] signal_in,
  output logic [15:0] signal_out,
  output logic        done_out
);

  logic [15:0]        hist [256];
  logic [7:0]         wr_ptr;
  logic [8:0]         fill_cnt;
  logic [15:0]        tap_next;
  logic [15:0]        tap_q;
  logic [4:0]         scale_q;
  logic               vld1;
  logic signed [21:0] prod;
  logic signed [17:0] scaled_q;
  logic               vld2;
  logic [15:0]        limited;
  logic               unused_bits;

  // Delay 0 bypasses the memory; taps older than the fill count read as zero.
  always_comb begin
    tap_next = 16'd0;
    if (delay_in == 8'd0)
      tap_next = signal_in;
    else if ({1'b0, delay_in} <= fill_cnt)
      tap_next = hist[wr_ptr - delay_in];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in && ready_in)
      hist[wr_ptr] <= signal_in;
  end

  assign prod = $signed(tap_q) * $signed({1'b0, scale_q});

  always_comb begin
`ifdef DELAY_AND_SCALE_SATURATE_EN
    unused_bits = ^prod[3:0];
    if (scaled_q > 18'sd32767)
      limited = 16'h7FFF;
    else if (scaled_q < -18'sd32768)
      limited = 16'h8000;
    else
      limited = scaled_q[15:0];
`else
    unused_bits = ^{prod[3:0], scaled_q[17:16]};
    limited = scaled_q[15:0];
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      wr_ptr     <= 8'd0;
      fill_cnt   <= 9'd0;
      tap_q      <= 16'd0;
      scale_q    <= 5'd0;
      vld1       <= 1'b0;
      scaled_q   <= 18'sd0;
      vld2       <= 1'b0;
      signal_out <= 16'd0;
      done_out   <= 1'b0;
    end else begin
      vld1     <= ready_in;
      vld2     <= vld1;
      done_out <= vld2;
      if (ready_in) begin
        wr_ptr  <= wr_ptr + 8'd1;
        tap_q   <= tap_next;
        scale_q <= scale_in;
        if (fill_cnt != 9'd256)
          fill_cnt <= fill_cnt + 9'd1;
      end
      // Dropping the low 4 product bits is an arithmetic shift with floor rounding.
      if (vld1)
        scaled_q <= prod[21:4];
      if (vld2)
        signal_out <= limited;
    end
  end

endmodule

// File: tb/tb_delay_and_scale.sv
// Directed self-checking bench for delay_and_scale; expectations follow DELAY_AND_SCALE_SATURATE_EN.
module tb_delay_and_scale;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        ready_in;
  logic [7:0]  delay_in;
  logic [4:0]  scale_in;
  logic [15:0] signal_in;
  logic [15:0] signal_out;
  logic        done_out;

  int n_checks = 0;
  int n_fail   = 0;

  delay_and_scale dut (
    .clk_in(clk_in), .reset_in(reset_in), .ready_in(ready_in), .delay_in(delay_in),
    .scale_in(scale_in), .signal_in(signal_in), .signal_out(signal_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic apply_reset();
    @(negedge clk_in);
    reset_in = 1'b0;
    ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b1;
  endtask

  // One strobe; returns done_out after edges k+1 and k+2 and signal_out after k+2.
  task automatic do_strobe(input logic [7:0] d, input logic [4:0] s, input logic [15:0] x,
                           output logic [15:0] res, output logic d1, output logic d2);
    @(negedge clk_in);
    ready_in = 1'b1; delay_in = d; scale_in = s; signal_in = x;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    @(posedge clk_in); #1;
    d1 = done_out;
    @(posedge clk_in); #1;
    d2  = done_out;
    res = signal_out;
  endtask

  task automatic test_reset();
    logic [15:0] r; logic d1, d2;
    @(negedge clk_in);
    reset_in = 1'b0; ready_in = 1'b1; delay_in = 8'd0; scale_in = 5'd16; signal_in = 16'd999;
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++;
    if (signal_out !== 16'd0 || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: signal_out=%0d done_out=%b, want 0/0", signal_out, done_out);
    end
    // First edge with reset released accepts the strobe.
    @(negedge clk_in);
    reset_in = 1'b1; ready_in = 1'b1; signal_in = 16'd7;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    n_checks++;
    if (done_out !== 1'b1 || signal_out !== 16'd7) begin
      n_fail++;
      $display("FAIL first_edge_after_reset: signal_out=%0d done_out=%b, want 7/1", signal_out, done_out);
    end
    // Sample strobed during reset must not be in history: delay 2 reaches behind the only sample.
    do_strobe(8'd2, 5'd16, 16'd5, r, d1, d2);
    n_checks++;
    if (r !== 16'd0 || {d1, d2} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_strobe_ignored: signal_out=%0d done=%b%b, want 0 done=01", r, d1, d2);
    end
  endtask

  task automatic test_scale_floor();
    logic [15:0] r; logic d1, d2;
    do_strobe(8'd0, 5'd8, 16'd1000, r, d1, d2);
    n_checks++;
    if (r !== 16'd500 || {d1, d2} !== 2'b01) begin
      n_fail++;
      $display("FAIL half_gain_pos: got %0d done=%b%b, want 500 done=01", $signed(r), d1, d2);
    end
    do_strobe(8'd0, 5'd8, -16'sd1001, r, d1, d2);
    n_checks++;
    if (r !== 16'hFE0B) begin
      n_fail++;
      $display("FAIL half_gain_neg_floor: got %0d, want -501", $signed(r));
    end
    do_strobe(8'd0, 5'd1, -16'sd1, r, d1, d2);
    n_checks++;
    if (r !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL tiny_gain_floor: got %0d, want -1", $signed(r));
    end
    do_strobe(8'd0, 5'd0, 16'd1234, r, d1, d2);
    n_checks++;
    if (r !== 16'd0) begin
      n_fail++;
      $display("FAIL mute: got %0d, want 0", $signed(r));
    end
    do_strobe(8'd0, 5'd16, -16'sd5, r, d1, d2);
    n_checks++;
    if (r !== 16'hFFFB) begin
      n_fail++;
      $display("FAIL unity_neg: got %0d, want -5", $signed(r));
    end
    // Output must hold while idle.
    repeat (4) @(posedge clk_in);
    #1;
    n_checks++;
    if (signal_out !== 16'hFFFB || done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: signal_out=%0d done_out=%b, want -5/0", $signed(signal_out), done_out);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] r; logic d1, d2;
    logic [15:0] exp_pos, exp_neg;
`ifdef DELAY_AND_SCALE_SATURATE_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'hF7FE; exp_neg = 16'h0800;
`endif
    do_strobe(8'd0, 5'd31, 16'h7FFF, r, d1, d2);
    n_checks++;
    if (r !== exp_pos) begin
      n_fail++;
      $display("FAIL overflow_pos: got %0d, want %0d", $signed(r), $signed(exp_pos));
    end
    do_strobe(8'd0, 5'd31, 16'h8000, r, d1, d2);
    n_checks++;
    if (r !== exp_neg) begin
      n_fail++;
      $display("FAIL overflow_neg: got %0d, want %0d", $signed(r), $signed(exp_neg));
    end
  endtask

  task automatic test_delay25();
    logic [15:0] r; logic d1, d2;
    apply_reset();
    for (int n = 1; n <= 40; n++) begin
      do_strobe(8'd25, 5'd16, 16'(n), r, d1, d2);
      n_checks++;
      if (r !== ((n > 25) ? 16'(n - 25) : 16'd0) || {d1, d2} !== 2'b01) begin
        n_fail++;
        $display("FAIL delay25 strobe %0d: got %0d done=%b%b, want %0d done=01",
                 n, r, d1, d2, (n > 25) ? n - 25 : 0);
      end
    end
  endtask

  task automatic test_delay255_wrap();
    logic [15:0] r; logic d1, d2;
    apply_reset();
    for (int n = 1; n <= 300; n++) begin
      do_strobe(8'd255, 5'd16, 16'(n), r, d1, d2);
      n_checks++;
      if (r !== ((n >= 256) ? 16'(n - 255) : 16'd0)) begin
        n_fail++;
        $display("FAIL delay255 strobe %0d: got %0d, want %0d", n, r, (n >= 256) ? n - 255 : 0);
      end
    end
  endtask

  // Ten consecutive strobes, delay 3, gain alternating 1.0 / 0.5 per strobe.
  task automatic test_back_to_back();
    int j, exp_v;
    apply_reset();
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk_in);
      if (c < 10) begin
        ready_in = 1'b1; delay_in = 8'd3; signal_in = 16'(10 * (c + 1));
        scale_in = (c % 2 == 1) ? 5'd8 : 5'd16;
      end else begin
        ready_in = 1'b0;
      end
      @(posedge clk_in); #1;
      j = c - 2;
      exp_v = (j >= 3) ? (10 * (j - 2) * ((j % 2 == 1) ? 8 : 16)) / 16 : 0;
      n_checks++;
      if (done_out !== ((c >= 2 && c < 12) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL burst_done cycle %0d: got %b", c, done_out);
      end else if (done_out === 1'b1 && signal_out !== 16'(exp_v)) begin
        n_fail++;
        $display("FAIL burst_value strobe %0d: got %0d, want %0d", j, signal_out, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] r; logic d1, d2;
    apply_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk_in);
      ready_in = (c <= 5); delay_in = 8'd0; scale_in = 5'd16; signal_in = 16'(100 * (c + 1));
      reset_in = (c == 5) ? 1'b0 : 1'b1;
      @(posedge clk_in); #1;
      n_checks++;
      if (c >= 2 && c <= 4) begin
        if (done_out !== 1'b1 || signal_out !== 16'(100 * (c - 1))) begin
          n_fail++;
          $display("FAIL pre_reset_out cycle %0d: got %0d done=%b, want %0d done=1",
                   c, signal_out, done_out, 100 * (c - 1));
        end
      end else if (c >= 5) begin
        if (done_out !== 1'b0 || signal_out !== 16'd0) begin
          n_fail++;
          $display("FAIL post_reset_quiet cycle %0d: got %0d done=%b, want 0 done=0",
                   c, signal_out, done_out);
        end
      end else if (done_out !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_start cycle %0d: done=%b, want 0", c, done_out);
      end
    end
    ready_in = 1'b0;
    // Delay 252 from pointer 0 points at pre-reset data, which must read as 0.
    do_strobe(8'd252, 5'd16, 16'd1, r, d1, d2);
    n_checks++;
    if (r !== 16'd0) begin
      n_fail++;
      $display("FAIL stale_history: got %0d, want 0", r);
    end
    do_strobe(8'd3, 5'd16, 16'd2, r, d1, d2);
    n_checks++;
    if (r !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_tap2: got %0d, want 0", r);
    end
    do_strobe(8'd3, 5'd16, 16'd3, r, d1, d2);
    n_checks++;
    if (r !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_tap3: got %0d, want 0", r);
    end
    do_strobe(8'd3, 5'd16, 16'd4, r, d1, d2);
    n_checks++;
    if (r !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset_tap4: got %0d, want 1", r);
    end
  endtask

  initial begin
    reset_in = 1'b0; ready_in = 1'b0; delay_in = 8'd0; scale_in = 5'd0; signal_in = 16'd0;
    test_reset();
    test_scale_floor();
    test_overflow();
    test_delay25();
    test_delay255_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
